// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: 2-flop synchronizer, centre-sampling FSM, one-cycle valid/break strobes.
// Optional BREAK detection is enabled by defining UART_RX_BREAK_EN.
module uart_rx_unit #(
    parameter int BIT_RATE = 9600,
    parameter int CLK_HZ   = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       uart_rx_en,
    output logic       uart_rx_break,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             rxd_meta_q, rxd_s_q;

    // Synchronizer idles high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

`ifdef UART_RX_BREAK_EN
    logic break_q, break_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            break_q <= 1'b0;
        end else begin
            break_q <= break_d;
        end
    end

    assign uart_rx_break = break_q;
`else
    assign uart_rx_break = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        valid_d   = 1'b0;
`ifdef UART_RX_BREAK_EN
        break_d   = 1'b0;
`endif
        // Dropping the enable abandons any frame in progress without touching the output byte.
        if (state_q != IDLE && !uart_rx_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (uart_rx_en && !rxd_s_q) begin
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                        state_d   = START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_END) begin
                        cnt_d   = '0;
                        state_d = rxd_s_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_END) begin
                        cnt_d     = '0;
                        shift_d   = {rxd_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            data_d  = {rxd_s_q, shift_q[7:1]};
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_END) begin
                        cnt_d = '0;
                        if (rxd_s_q) begin
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
`ifdef UART_RX_BREAK_EN
                            break_d = (shift_q == 8'h00);
`endif
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign uart_rx_valid = valid_q;
    assign uart_rx_data  = data_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit: stimulus pushes expected bytes, a monitor pops them on each valid strobe.
// A faster line rate (100 clocks per bit) keeps the run short while exercising the same timing structure.
module tb_uart_rx_unit;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BIT_RATE = 500_000;
    localparam int T        = CLK_HZ / BIT_RATE;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_valid   = 0;
    int n_break   = 0;
    int n_pushed  = 0;
    logic prev_strobe = 1'b0;
    logic [7:0] sb[$];

    uart_rx_unit #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .uart_rx_en   (uart_rx_en),
        .uart_rx_break(uart_rx_break),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data)
    );

    always #10 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one 8N1 frame on the line; pushed frames also expect the byte to be visible during the stop bit.
    task automatic apply_stimulus(input logic [7:0] b, input bit push, input int idle_bits);
        if (push) begin
            sb.push_back(b);
            n_pushed++;
        end
        uart_rxd = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (T) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        if (push) check_output("data_in_stop_bit", {24'h0, uart_rx_data}, {24'h0, b});
        repeat (T - 20) @(negedge clk);
        if (push) check_output("sb_drained", sb.size(), 0);
        repeat (idle_bits * T) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (uart_rx_valid) begin
                n_valid++;
                if (sb.size() == 0) begin
                    check_output("valid_unexpected", 1, 0);
                end else begin
                    check_output("rx_byte", {24'h0, uart_rx_data}, {24'h0, sb.pop_front()});
                end
            end
            if (uart_rx_break) n_break++;
            if (uart_rx_valid || uart_rx_break) begin
                check_output("strobe_spacing", {31'h0, prev_strobe}, 0);
                check_output("strobe_exclusive", {31'h0, uart_rx_valid & uart_rx_break}, 0);
            end
            prev_strobe = uart_rx_valid | uart_rx_break;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    logic [7:0] burst[10] = '{8'h3A, 8'hC3, 8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'h12, 8'h96, 8'hE7};

    initial begin
        int v0;
        int b0;
        int exp_break;
`ifdef UART_RX_BREAK_EN
        exp_break = 1;
`else
        exp_break = 0;
`endif
        reset      = 1'b1;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        repeat (5) @(negedge clk);
        check_output("reset_data", {24'h0, uart_rx_data}, 0);
        check_output("reset_valid", {31'h0, uart_rx_valid}, 0);
        check_output("reset_break", {31'h0, uart_rx_break}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        apply_stimulus(8'hA5, 1, 1);

        for (int i = 0; i < 10; i++) apply_stimulus(burst[i], 1, 1);

        // Short glitch must be rejected at the start-bit centre.
        v0 = n_valid;
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * T) @(negedge clk);
        check_output("glitch_no_valid", n_valid, v0);
        check_output("glitch_data_kept", {24'h0, uart_rx_data}, 32'hE7);

        // Line held low for 12 bit periods.
        v0 = n_valid;
        b0 = n_break;
        uart_rxd = 1'b0;
        repeat (12 * T) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * T) @(negedge clk);
        check_output("break_pulses", n_break - b0, exp_break);
        check_output("break_no_valid", n_valid, v0);
        check_output("break_data", {24'h0, uart_rx_data}, 0);
        apply_stimulus(8'h3C, 1, 1);

        // Receiver disabled: frame ignored.
        v0 = n_valid;
        b0 = n_break;
        uart_rx_en = 1'b0;
        apply_stimulus(8'h55, 0, 1);
        check_output("disabled_no_valid", n_valid, v0);
        check_output("disabled_no_break", n_break, b0);
        check_output("disabled_data_kept", {24'h0, uart_rx_data}, 32'h3C);
        uart_rx_en = 1'b1;
        repeat (T) @(negedge clk);
        apply_stimulus(8'h55, 1, 1);

        // Reset in the middle of data bit 3 of 0xF0.
        uart_rxd = 1'b0;
        repeat (4 * T) @(negedge clk);
        repeat (T / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("midframe_reset_data", {24'h0, uart_rx_data}, 0);
        check_output("midframe_reset_valid", {31'h0, uart_rx_valid}, 0);
        check_output("midframe_reset_break", {31'h0, uart_rx_break}, 0);
        uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2 * T) @(negedge clk);
        v0 = n_valid;
        apply_stimulus(8'h3C, 1, 1);
        check_output("post_reset_one_valid", n_valid - v0, 1);

        check_output("sb_empty_final", sb.size(), 0);
        check_output("total_valid", n_valid, n_pushed);
        check_output("total_break", n_break, exp_break);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

UART serial receiver for 8N1 frames: one start bit, 8 data bits LSB first, one stop bit, no parity. It oversamples the asynchronous `uart_rxd` pin with the system clock and delivers each received byte on a parallel bus with a one-cycle valid strobe. It sits between the board-level RX pin and any byte-consuming logic, and is the receive half of the team UART.

## Interface
- `BIT_RATE`, default 9600: line rate in bit/s.
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- Derived localparam `CYCLES_PER_BIT` = `CLK_HZ / BIT_RATE`, integer division; 434 at 50 MHz / 115200. Hierarchically visible to benches.
- Derived localparam `HALF_BIT` = `CYCLES_PER_BIT / 2`.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rxd`  in  1  serial line, asynchronous, idle high.
- `uart_rx_en`  in  1  receive enable.
- `uart_rx_break`  out  1  one-cycle pulse when a BREAK is detected.
- `uart_rx_valid`  out  1  one-cycle pulse when a frame completes with a good stop bit.
- `uart_rx_data`  out  8  last received byte; held until the next byte is loaded.

## Operation
- Input path:
  - 2-flop synchronizer on `uart_rxd`; the synchronizer resets to 1.
  - All decisions use the synchronized value `rxd_s`.
- The FSM has five states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: if `uart_rx_en`=1 and `rxd_s`=0, clear the counter and go to START.
  - START: at count `HALF_BIT`-1 (start-bit centre), go to DATA if `rxd_s`=0. Otherwise the event is a glitch: return to IDLE.
  - DATA: every `CYCLES_PER_BIT` cycles, shift `rxd_s` into the MSB of an 8-bit shift register (LSB-first reception).
    - After the 8th sample, copy the assembled byte to `uart_rx_data` in the same cycle, then go to STOP.
  - STOP: sample once at `CYCLES_PER_BIT` after the last data sample.
    - Stop bit = 1: pulse `uart_rx_valid`, go to IDLE.
    - Stop bit = 0 and byte = 0x00: BREAK. Pulse `uart_rx_break` (see Configuration), go to WAIT_HIGH.
    - Stop bit = 0 and byte ≠ 0x00: framing error. No strobe; go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s`=1, then go to IDLE.
- `uart_rx_en`=0 in any state other than IDLE aborts the frame:
  - Next cycle the FSM is in IDLE.
  - `uart_rx_data` is unchanged and no strobe is issued.
- `uart_rx_valid` and `uart_rx_break` are mutually exclusive and never high in adjacent cycles.

## Timing
- Reset values:
  - FSM in IDLE; counter 0; shift register 0x00.
  - `uart_rx_data`=0x00, `uart_rx_valid`=0, `uart_rx_break`=0.
- Reset mid-frame takes effect immediately (asynchronous) and discards the frame.
- Counter width is `$clog2(CYCLES_PER_BIT+1)`. The counter wraps to 0 on each sample point.
- Latency from the line falling edge, with `T`=`CYCLES_PER_BIT`:
  - Data bit k is sampled at 2 + `HALF_BIT` + (k+1)·`T` cycles (±1).
  - `uart_rx_data` updates at bit 7's sample, i.e. ≈8.5 bit periods after the start edge, before the stop bit is checked.
  - `uart_rx_valid` rises ≈9.5 bit periods after the start edge.
- Strobes are registered and last exactly one cycle.
- A new start bit is accepted from the cycle after STOP returns to IDLE, so back-to-back frames with a 1-bit stop are supported.

## Configuration
- Macro `UART_RX_BREAK_EN`.
- Defined: BREAK detection as described; `uart_rx_break` pulses on a zero byte with a low stop bit.
- Undefined:
  - `uart_rx_break` is tied to 0.
  - A zero byte with a low stop bit is treated as an ordinary framing error: no strobe, WAIT_HIGH.

## Test plan
Common setup: `CLK_HZ`=50_000_000, `BIT_RATE`=115200, bit period 8680 ns, `CYCLES_PER_BIT`=434.
- Send 0xA5, `uart_rx_en`=1 -> `uart_rx_data`=0xA5 within 1000 ns after the stop bit begins; one `uart_rx_valid` pulse at mid stop bit; `uart_rx_break` stays 0.
- Send 10 random bytes back-to-back with one idle bit between frames -> each byte matches, exactly 10 valid pulses, 0 fails.
- 100 ns low glitch on `uart_rxd` -> no valid pulse, `uart_rx_data` unchanged, FSM back in IDLE before the next frame.
- Hold `uart_rxd` low for 12 bit periods, then high, with `UART_RX_BREAK_EN` defined -> one `uart_rx_break` pulse, no valid, `uart_rx_data`=0x00. Next frame 0x3C is received correctly.
- `uart_rx_en`=0 while 0x55 is sent -> no strobes, `uart_rx_data` keeps its prior value. Re-enable, send 0x55 -> received.
- Assert `reset` during data bit 3 of 0xF0 -> outputs 0 immediately. After release, send 0x3C -> `uart_rx_data`=0x3C with one valid pulse.
